// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: CPU data-port responder with word RAM, cycle counter, output FIFO and sticky status flags.
module dmem_mmio_responder #(
  parameter int          DEPTH      = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] fifo_q [FIFO_DEPTH];
  logic [31:0] cycle_q, cycle_d, status;
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, err_q, err_d;
  logic in_ram, is_cyc, is_out, is_st, ok, wr_ok, full, empty, pop, push, do_push;
  assign in_ram = address < RAM_BYTES;
  assign is_cyc = address == MMIO_BASE;
  assign is_out = address == MMIO_BASE + 32'd4;
  assign is_st = address == MMIO_BASE + 32'd8;
  assign ok = address[1:0] == 2'b00 && (in_ram || is_cyc || is_out || is_st);
  assign wr_ok = MemWrite && ok;
  assign full = cnt_q == FULL_CNT;
  assign empty = cnt_q == '0;
  assign out_valid = !empty;
  assign out_data = fifo_q[rd_q];
  assign err = err_q;
  assign pop = out_valid && out_ready;
  assign push = wr_ok && is_out;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || pop);
  assign status = 32'({err_q, ovf_q, cnt_q, empty, full});
  always_comb begin
    ReadData = !(MemRead && ok) ? '0 : in_ram ? mem_q[address[AW+1:2]] : is_cyc ? cycle_q : is_st ? status : '0;
    cycle_d = (wr_ok && is_cyc) ? writeData : cycle_q + 32'd1;
    cnt_d = cnt_q + CW'(do_push) - CW'(pop);
    ovf_d = (push && full && !pop) || (ovf_q && !(wr_ok && is_st && writeData[5]));
    err_d = ((MemRead || MemWrite) && !ok) || (err_q && !(wr_ok && is_st && writeData[6]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      cycle_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (wr_ok && in_ram) mem_q[address[AW+1:2]] <= writeData;
      if (do_push) begin
        fifo_q[wr_q] <= writeData;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cycle_q <= cycle_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: scenario tasks plus randomized traffic against a queue-based reference model.
module tb_dmem_mmio_responder;
  localparam logic [31:0] MB = 32'h0000_FF00;
  logic clk = 0, reset = 1, MemWrite = 0, MemRead = 0, out_ready = 0;
  logic [31:0] address = 0, writeData = 0;
  logic [31:0] ReadData, out_data;
  logic out_valid, err;
  int tests = 0, fails = 0;
  logic [31:0] m_ram [256];
  logic [31:0] m_cyc;
  logic [31:0] m_q [$];
  logic m_ovf, m_err;

  always #5 clk = ~clk;

  dmem_mmio_responder dut (
    .clk(clk), .reset(reset), .address(address), .writeData(writeData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .err(err)
  );

  function automatic int region(logic [31:0] a);
    if (a < 32'd1024) return 0;
    if (a == MB) return 1;
    if (a == MB + 4) return 2;
    if (a == MB + 8) return 3;
    return -1;
  endfunction

  function automatic logic [31:0] m_status();
    return {25'd0, m_err, m_ovf, 3'(m_q.size()), m_q.size() == 0, m_q.size() == 4};
  endfunction

  function automatic logic [31:0] m_read(logic rd, logic [31:0] a);
    int r = region(a);
    if (!rd || a[1:0] != 2'b00 || r < 0) return 32'h0;
    case (r)
      0: return m_ram[a[9:2]];
      1: return m_cyc;
      3: return m_status();
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_apply();
    int r = region(address);
    logic ok = address[1:0] == 2'b00 && r >= 0;
    logic set_ovf = 0;
    logic [31:0] nc = m_cyc + 1;
    if (reset) begin
      foreach (m_ram[i]) m_ram[i] = 0;
      m_cyc = 0;
      m_q.delete();
      m_ovf = 0;
      m_err = 0;
      return;
    end
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (MemWrite && ok)
      case (r)
        0: m_ram[address[9:2]] = writeData;
        1: nc = writeData;
        2: if (m_q.size() < 4) m_q.push_back(writeData); else set_ovf = 1;
        3: begin
          if (writeData[5]) m_ovf = 0;
          if (writeData[6]) m_err = 0;
        end
        default: ;
      endcase
    if (set_ovf) m_ovf = 1;
    if ((MemRead || MemWrite) && !ok) m_err = 1;
    m_cyc = nc;
  endtask

  task automatic tick();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic we, logic re, logic [31:0] a, logic [31:0] d);
    MemWrite = we;
    MemRead = re;
    address = a;
    writeData = d;
  endtask

  task automatic test_reset();
    reset = 1; out_ready = 1;
    drv(1, 0, 32'h10, 32'h1234);
    tick();
    reset = 0; out_ready = 0;
    drv(0, 0, 0, 0); #1;
    tests++; if (ReadData !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", ReadData); end
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin fails++; $display("FAIL reset_fifo got v=%b d=%h want v=0 d=0", out_valid, out_data); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    drv(0, 1, MB + 8, 0); #1;
    tests++; if (ReadData !== 32'h2) begin fails++; $display("FAIL reset_status got %h want 2", ReadData); end
    drv(0, 1, MB, 0); #1;
    tests++; if (ReadData !== 32'h0) begin fails++; $display("FAIL reset_cycle got %h want 0", ReadData); end
    tick();
    drv(0, 1, 32'h10, 0); #1;
    tests++; if (ReadData !== 32'h0) begin fails++; $display("FAIL reset_ram got %h want 0", ReadData); end
    tick();
  endtask

  task automatic test_ram();
    drv(1, 0, 32'h10, 32'hDEAD_BEEF); tick();
    drv(0, 1, 32'h10, 0); #1;
    tests++; if (ReadData !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_load got %h want deadbeef", ReadData); end
    drv(0, 1, 32'h14, 0); #1;
    tests++; if (ReadData !== 32'h0) begin fails++; $display("FAIL ram_other got %h want 0", ReadData); end
    drv(0, 0, 32'h10, 0); #1;
    tests++; if (ReadData !== 32'h0) begin fails++; $display("FAIL ram_noread got %h want 0", ReadData); end
    drv(1, 1, 32'h10, 32'h0BAD_F00D); #1;
    tests++; if (ReadData !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_rw_pre got %h want deadbeef", ReadData); end
    tick();
    drv(0, 1, 32'h10, 0); #1;
    tests++; if (ReadData !== 32'h0BAD_F00D) begin fails++; $display("FAIL ram_rw_post got %h want 0badf00d", ReadData); end
    tick();
  endtask

  task automatic test_cycle();
    reset = 1; drv(0, 0, 0, 0); tick();
    reset = 0;
    repeat (10) tick();
    drv(0, 1, MB, 0); #1;
    tests++; if (ReadData !== 32'd10 || m_read(1, MB) !== 32'd10) begin fails++; $display("FAIL cycle_count got %h want 10", ReadData); end
    drv(1, 0, MB, 32'hFFFF_FFFE); tick();
    drv(0, 0, 0, 0); tick(); tick();
    drv(0, 1, MB, 0); #1;
    tests++; if (ReadData !== 32'h0) begin fails++; $display("FAIL cycle_wrap got %h want 0", ReadData); end
    tick();
  endtask

  task automatic test_fifo_ovf();
    reset = 1; drv(0, 0, 0, 0); out_ready = 0; tick();
    reset = 0;
    for (int i = 1; i <= 5; i++) begin drv(1, 0, MB + 4, i); tick(); end
    drv(0, 1, MB + 8, 0); #1;
    tests++; if (ReadData !== 32'h31) begin fails++; $display("FAIL ovf_status got %h want 31", ReadData); end
    drv(0, 0, 0, 0); out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      tests++; if (out_valid !== 1'b1 || out_data !== i) begin fails++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i); end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b want 0", out_valid); end
    drv(0, 1, MB + 8, 0); #1;
    tests++; if (ReadData !== 32'h22) begin fails++; $display("FAIL drained_status got %h want 22", ReadData); end
    out_ready = 0; tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_seq [4] = '{32'd12, 32'd13, 32'd14, 32'd9};
    drv(1, 0, MB + 8, 32'h20); tick();
    for (int i = 11; i <= 14; i++) begin drv(1, 0, MB + 4, i); tick(); end
    drv(1, 0, MB + 4, 32'd9); out_ready = 1; #1;
    tests++; if (out_data !== 32'd11) begin fails++; $display("FAIL b2b_head got %h want 11", out_data); end
    tick();
    out_ready = 0; drv(0, 1, MB + 8, 0); #1;
    tests++; if (ReadData !== 32'h11) begin fails++; $display("FAIL b2b_status got %h want 11", ReadData); end
    drv(0, 0, 0, 0); out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin fails++; $display("FAIL b2b_drain_%0d got %h want %h", i, out_data, exp_seq[i]); end
      tick();
    end
    out_ready = 0;
  endtask

  task automatic test_errors();
    reset = 1; drv(0, 0, 0, 0); tick();
    reset = 0;
    drv(1, 0, 32'h0, 32'h5555_AAAA); tick();
    drv(0, 1, 32'h3, 0); #1;
    tests++; if (ReadData !== 32'h0 || err !== 1'b0) begin fails++; $display("FAIL misalign_load got rd=%h err=%b want 0/0", ReadData, err); end
    tick();
    drv(0, 0, 0, 0); #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err); end
    drv(1, 0, 32'h8000, 32'h1234_5678); tick();
    drv(0, 1, 32'h0, 0); #1;
    tests++; if (ReadData !== 32'h5555_AAAA) begin fails++; $display("FAIL unmapped_store got %h want 5555aaaa", ReadData); end
    drv(0, 1, MB + 4, 0); #1;
    tests++; if (ReadData !== 32'h0) begin fails++; $display("FAIL out_read got %h want 0", ReadData); end
    drv(1, 0, MB + 9, 32'h40); tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL misaligned_w1c got %b want 1", err); end
    drv(1, 0, MB + 8, 32'h40); tick();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err); end
    drv(0, 1, MB + 12, 0); tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL unmapped_load_err got %b want 1", err); end
    drv(1, 0, MB + 8, 32'h40); tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    drv(1, 0, MB + 4, 32'd7); tick();
    drv(1, 0, MB + 4, 32'd8); tick();
    reset = 1; drv(1, 0, 32'h20, 32'hCAFE); tick();
    drv(1, 0, MB + 4, 32'h99); out_ready = 1; tick();
    reset = 0; out_ready = 0; drv(0, 0, 0, 0); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_fifo got %b want 0", out_valid); end
    tick();
    drv(0, 1, MB, 0); #1;
    tests++; if (ReadData !== 32'd1) begin fails++; $display("FAIL midreset_cycle got %h want 1", ReadData); end
    drv(0, 1, 32'h20, 0); #1;
    tests++; if (ReadData !== 32'h0) begin fails++; $display("FAIL midreset_ram got %h want 0", ReadData); end
    drv(0, 1, MB + 8, 0); #1;
    tests++; if (ReadData !== 32'h2) begin fails++; $display("FAIL midreset_status got %h want 2", ReadData); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, exp;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0, 1: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        2: a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
        3: a = MB;
        4: a = MB + 4;
        5: a = MB + 8;
        6: a = ($urandom_range(0, 1) == 1) ? MB + 12 : 32'h8000 + 4 * $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      reset = $urandom_range(0, 80) == 0;
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
      out_ready = $urandom_range(0, 2) == 0;
      #1;
      exp = m_read(MemRead, address);
      tests++; if (ReadData !== exp) begin fails++; $display("FAIL rnd_rdata n=%0d a=%h got %h want %h", n, a, ReadData, exp); end
      tests++; if (out_valid !== (m_q.size() > 0)) begin fails++; $display("FAIL rnd_valid n=%0d got %b want %b", n, out_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        tests++; if (out_data !== m_q[0]) begin fails++; $display("FAIL rnd_data n=%0d got %h want %h", n, out_data, m_q[0]); end
      end
      tests++; if (err !== m_err) begin fails++; $display("FAIL rnd_err n=%0d got %b want %b", n, err, m_err); end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_cycle();
    test_fifo_ovf();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
